// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states,
// RISC-V load/store funct3 encodings and access-size decode.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // Access size in bytes; the sign bit does not affect the size.
   function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
      logic [3:0] n;
      case (funct3)
         3'b000, 3'b100: n = 4'd1;
         3'b001, 3'b101: n = 4'd2;
         3'b010, 3'b110: n = 4'd4;
         3'b011, 3'b111: n = 4'd8;
         default:        n = 4'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU: legality check, byte enables,
// store-data shift and load extract with sign/zero extension.
module lsu_align #(
   parameter int XLEN = 32
) (
   input  logic                        mem_read,
   input  logic                        mem_write,
   input  logic [2:0]                  funct3,
   input  logic [$clog2(XLEN/8)-1:0]   off,
   input  logic [XLEN-1:0]             wdata,
   output logic                        legal,
   output logic [XLEN/8-1:0]           be,
   output logic [XLEN-1:0]             wdata_sh,
   input  logic [2:0]                  ld_funct3,
   input  logic [$clog2(XLEN/8)-1:0]   ld_off,
   input  logic [XLEN-1:0]             rsp_rdata,
   output logic [XLEN-1:0]             ld_data
);
   import lsu_pkg::*;

   localparam int NB = XLEN / 8;

   logic [3:0]      bytes_s;
   logic [3:0]      ld_bytes_s;
   logic [NB-1:0]   mask_s;
   logic [XLEN-1:0] shifted_s;
   logic            bad_size_s;
   logic            bad_sign_s;
   logic            misaligned_s;
   logic            msb_s;
   logic            fill_s;

   assign bytes_s    = size_bytes(funct3);
   assign ld_bytes_s = size_bytes(ld_funct3);

   // Legality of the access presented by the core
   always_comb begin
      bad_size_s   = (funct3[1:0] == 2'b11) && (XLEN == 32);
      bad_sign_s   = funct3[2] && (mem_write || (funct3[1:0] == 2'b11));
      misaligned_s = ((4'(off) & (bytes_s - 4'd1)) != 4'd0);
      legal        = (mem_read ^ mem_write) && !bad_size_s && !bad_sign_s && !misaligned_s;
   end

   // Byte-enable mask and store lane shift
   always_comb begin
      mask_s = {NB{1'b0}};
      for (int i = 0; i < NB; i++) begin
         mask_s[i] = (i < int'(bytes_s));
      end
      be       = mask_s << off;
      wdata_sh = wdata << {off, 3'b000};
   end

   // Load extract and extend; bits above the access size take the fill value
   always_comb begin
      shifted_s = rsp_rdata >> {ld_off, 3'b000};
      case (ld_funct3[1:0])
         2'b00:   msb_s = shifted_s[7];
         2'b01:   msb_s = shifted_s[15];
         2'b10:   msb_s = shifted_s[31];
         2'b11:   msb_s = shifted_s[XLEN-1];
         default: msb_s = 1'b0;
      endcase
      fill_s  = msb_s & ~ld_funct3[2];
      ld_data = shifted_s;
      for (int i = 0; i < XLEN; i++) begin
         if (i >= 8 * int'(ld_bytes_s)) begin
            ld_data[i] = fill_s;
         end else begin
            ld_data[i] = shifted_s[i];
         end
      end
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit between core and data cache: captures an access, issues a
// valid/ready request, waits for the response (with timeout) and holds stall.
module lsu_mem_port #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [2:0]          funct3,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [XLEN-1:0]     wdata,
   output logic [XLEN-1:0]     rdata,
   output logic                stall,
   output logic                fault,
   output logic                timeout_err,
   output logic                req_valid,
   input  logic                req_ready,
   output logic                req_we,
   output logic [ADDR_W-1:0]   req_addr,
   output logic [XLEN-1:0]     req_wdata,
   output logic [XLEN/8-1:0]   req_be,
   input  logic                rsp_valid,
   input  logic [XLEN-1:0]     rsp_rdata
);
   import lsu_pkg::*;

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // The counter starts at 0 in the first WAIT cycle, so this value marks the TIMEOUT-th one.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_e        state_r;
   lsu_state_e        next_state_s;
   logic [CNT_W-1:0]  cnt_r;
   logic              we_r;
   logic [2:0]        f3_r;
   logic [OFF_W-1:0]  off_r;
   logic [ADDR_W-1:0] req_addr_r;
   logic [XLEN-1:0]   req_wdata_r;
   logic [NB-1:0]     req_be_r;
   logic [XLEN-1:0]   rdata_r;
   logic              timeout_err_r;

   logic              access_s;
   logic              legal_s;
   logic              capture_s;
   logic              expire_s;
   logic              stall_s;
   logic              fault_s;
   logic [NB-1:0]     be_s;
   logic [XLEN-1:0]   wdata_sh_s;
   logic [XLEN-1:0]   ld_data_s;

   lsu_align #(.XLEN(XLEN)) u_align (
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .funct3    (funct3),
      .off       (addr[OFF_W-1:0]),
      .wdata     (wdata),
      .legal     (legal_s),
      .be        (be_s),
      .wdata_sh  (wdata_sh_s),
      .ld_funct3 (f3_r),
      .ld_off    (off_r),
      .rsp_rdata (rsp_rdata),
      .ld_data   (ld_data_s)
   );

   assign access_s = mem_read | mem_write;
   assign expire_s = (cnt_r == CNT_LAST);

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state, stall and fault decode
   always_comb begin
      next_state_s = state_r;
      stall_s      = 1'b0;
      fault_s      = 1'b0;
      capture_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (access_s && legal_s) begin
               stall_s      = 1'b1;
               capture_s    = 1'b1;
               next_state_s = REQ;
            end else begin
               fault_s      = access_s;
               next_state_s = IDLE;
            end
         end
         REQ: begin
            stall_s = 1'b1;
            if (req_ready) begin
               next_state_s = WAIT;
            end else begin
               next_state_s = REQ;
            end
         end
         WAIT: begin
            stall_s = 1'b1;
            if (rsp_valid || expire_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = WAIT;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Response timeout counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == REQ) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == WAIT) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Captured request fields, held stable until the next access
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         we_r        <= 1'b0;
         f3_r        <= 3'b000;
         off_r       <= {OFF_W{1'b0}};
         req_addr_r  <= {ADDR_W{1'b0}};
         req_wdata_r <= {XLEN{1'b0}};
         req_be_r    <= {NB{1'b0}};
      end else if (capture_s) begin
         we_r        <= mem_write;
         f3_r        <= funct3;
         off_r       <= addr[OFF_W-1:0];
         req_addr_r  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
         req_wdata_r <= wdata_sh_s;
         req_be_r    <= be_s;
      end
   end

   // Load result and timeout flag, both presented during DONE
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdata_r       <= {XLEN{1'b0}};
         timeout_err_r <= 1'b0;
      end else begin
         timeout_err_r <= (state_r == WAIT) && !rsp_valid && expire_s;
         if ((state_r == WAIT) && rsp_valid) begin
            rdata_r <= we_r ? {XLEN{1'b0}} : ld_data_s;
         end else if (((state_r == WAIT) && expire_s) || capture_s) begin
            rdata_r <= {XLEN{1'b0}};
         end
      end
   end

   assign stall       = stall_s;
   assign fault       = fault_s;
   assign req_valid   = (state_r == REQ);
   assign req_we      = we_r;
   assign req_addr    = req_addr_r;
   assign req_wdata   = req_wdata_r;
   assign req_be      = req_be_r;
   assign rdata       = rdata_r;
   assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a 32-bit instance with TIMEOUT=4 and a
// 64-bit instance, driven as a core and cache would and checked per scenario.
module tb_lsu_mem_port;
   import lsu_pkg::*;

   logic clock = 1'b0;
   logic rst_n;
   always #5 clock = ~clock;

   logic        a_rd, a_wr, a_ready, a_rsp_valid;
   logic [2:0]  a_f3;
   logic [31:0] a_addr, a_wdata, a_rsp_rdata;
   logic [31:0] a_rdata, a_req_addr, a_req_wdata;
   logic [3:0]  a_req_be;
   logic        a_stall, a_fault, a_terr, a_req_valid, a_req_we;

   logic        b_rd, b_wr, b_ready, b_rsp_valid;
   logic [2:0]  b_f3;
   logic [31:0] b_addr, b_req_addr;
   logic [63:0] b_wdata, b_rsp_rdata, b_rdata, b_req_wdata;
   logic [7:0]  b_req_be;
   logic        b_stall, b_fault, b_terr, b_req_valid, b_req_we;

   int total = 0;
   int bad   = 0;

   int          o_stall, o_fault, o_rv, o_terr;
   bit          o_done, o_terr_done, o_stable;
   logic        o_we;
   logic [31:0] o_rdata, o_addr, o_wdata;
   logic [3:0]  o_be;

   int          q_stall, q_fault, q_rv;
   bit          q_done;
   logic [63:0] q_rdata;
   logic [31:0] q_addr;
   logic [7:0]  q_be;

   lsu_mem_port #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) d32 (
      .clock(clock), .reset(rst_n), .mem_read(a_rd), .mem_write(a_wr), .funct3(a_f3),
      .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .stall(a_stall), .fault(a_fault),
      .timeout_err(a_terr), .req_valid(a_req_valid), .req_ready(a_ready), .req_we(a_req_we),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata)
   );

   lsu_mem_port #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) d64 (
      .clock(clock), .reset(rst_n), .mem_read(b_rd), .mem_write(b_wr), .funct3(b_f3),
      .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .stall(b_stall), .fault(b_fault),
      .timeout_err(b_terr), .req_valid(b_req_valid), .req_ready(b_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata)
   );

   // Plays core and cache for one access on the 32-bit instance; the core drops
   // the access once stall is low, the cache answers rsp_dly cycles after the handshake.
   task automatic drive32(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rsp,
                          input int rdy_dly, input int rsp_dly);
      int  req_seen = 0;
      int  wait_idx = 0;
      bit  hs = 0, responded = 0, active = 1;
      @(posedge clock); #1;
      a_rd = rd; a_wr = wr; a_f3 = f3; a_addr = ad; a_wdata = wd;
      a_rsp_rdata = rsp; a_rsp_valid = 1'b0; a_ready = (rdy_dly == 0);
      o_stall = 0; o_fault = 0; o_rv = 0; o_terr = 0;
      o_done = 0; o_terr_done = 0; o_stable = 1; o_we = 1'b0;
      o_rdata = 32'h0; o_addr = 32'h0; o_wdata = 32'h0; o_be = 4'h0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clock);
         if (a_fault) o_fault++;
         if (a_terr) o_terr++;
         if (a_req_valid) begin
            if (o_rv == 0) begin
               o_addr = a_req_addr; o_be = a_req_be; o_wdata = a_req_wdata; o_we = a_req_we;
            end else if (a_req_addr !== o_addr || a_req_be !== o_be ||
                         a_req_wdata !== o_wdata || a_req_we !== o_we) begin
               o_stable = 0;
            end
            o_rv++;
            req_seen++;
            if (a_ready) hs = 1;
         end
         if (a_stall) begin
            o_stall++;
         end else if (active) begin
            active = 0;
            if (o_rv != 0) begin
               o_done = 1; o_rdata = a_rdata; o_terr_done = a_terr;
            end
         end
         @(posedge clock); #1;
         if (!active) begin a_rd = 1'b0; a_wr = 1'b0; end
         a_ready = (req_seen >= rdy_dly);
         if (hs && !responded) begin
            wait_idx++;
            a_rsp_valid = (wait_idx == rsp_dly);
            if (a_rsp_valid) responded = 1;
         end else begin
            a_rsp_valid = 1'b0;
         end
      end
      a_rsp_valid = 1'b0; a_ready = 1'b0;
   endtask

   // Load on the 64-bit instance: immediate ready, response in the first WAIT cycle.
   task automatic drive64(input logic [2:0] f3, input logic [31:0] ad, input logic [63:0] rsp);
      bit hs = 0, responded = 0, active = 1;
      @(posedge clock); #1;
      b_rd = 1'b1; b_f3 = f3; b_addr = ad; b_rsp_rdata = rsp; b_rsp_valid = 1'b0; b_ready = 1'b1;
      q_stall = 0; q_fault = 0; q_rv = 0; q_done = 0; q_rdata = 64'h0; q_addr = 32'h0; q_be = 8'h0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (b_fault) q_fault++;
         if (b_req_valid) begin
            q_addr = b_req_addr; q_be = b_req_be; q_rv++; hs = 1;
         end
         if (b_stall) begin
            q_stall++;
         end else if (active) begin
            active = 0;
            if (q_rv != 0) begin q_done = 1; q_rdata = b_rdata; end
         end
         @(posedge clock); #1;
         if (!active) b_rd = 1'b0;
         if (hs && !responded) begin
            b_rsp_valid = 1'b1; responded = 1;
         end else begin
            b_rsp_valid = 1'b0;
         end
      end
      b_rsp_valid = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      total++; if ({a_stall, a_fault, a_terr, a_req_valid, a_req_we, a_req_be} !== 9'h0 || a_rdata !== 32'h0 || a_req_addr !== 32'h0 || a_req_wdata !== 32'h0) begin bad++; $display("FAIL reset32_outputs got stall=%b req_valid=%b rdata=%h want all zero", a_stall, a_req_valid, a_rdata); end
      total++; if ({b_stall, b_fault, b_terr, b_req_valid, b_req_we, b_req_be} !== 13'h0 || b_rdata !== 64'h0 || b_req_addr !== 32'h0 || b_req_wdata !== 64'h0) begin bad++; $display("FAIL reset64_outputs got stall=%b req_valid=%b rdata=%h want all zero", b_stall, b_req_valid, b_rdata); end
      @(posedge clock); #1; rst_n = 1'b1;
      @(negedge clock);
      total++; if (a_stall !== 1'b0 || a_req_valid !== 1'b0) begin bad++; $display("FAIL reset_release_idle got stall=%b req_valid=%b want 0 0", a_stall, a_req_valid); end
   endtask

   task automatic test_loads32;
      drive32(1'b1, 1'b0, F3_B, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 1);
      total++; if (o_addr !== 32'h0000_0100) begin bad++; $display("FAIL lb_req_addr got=%h want=%h", o_addr, 32'h0000_0100); end
      total++; if (o_be !== 4'b1000) begin bad++; $display("FAIL lb_req_be got=%b want=%b", o_be, 4'b1000); end
      total++; if (o_done !== 1'b1 || o_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got=%h done=%b want=%h", o_rdata, o_done, 32'hFFFF_FF80); end
      total++; if (o_stall !== 3) begin bad++; $display("FAIL lb_stall_cycles got=%0d want=3", o_stall); end
      total++; if (o_fault !== 0 || o_terr !== 0 || o_we !== 1'b0) begin bad++; $display("FAIL lb_flags got fault=%0d terr=%0d we=%b want 0 0 0", o_fault, o_terr, o_we); end
      drive32(1'b1, 1'b0, F3_BU, 32'h0000_0101, 32'h0, 32'h80FF_1234, 0, 1);
      total++; if (o_be !== 4'b0010 || o_rdata !== 32'h0000_0012) begin bad++; $display("FAIL lbu got be=%b rdata=%h want be=0010 rdata=00000012", o_be, o_rdata); end
      drive32(1'b1, 1'b0, F3_H, 32'h0000_0102, 32'h0, 32'h80FF_1234, 0, 1);
      total++; if (o_be !== 4'b1100 || o_rdata !== 32'hFFFF_80FF) begin bad++; $display("FAIL lh got be=%b rdata=%h want be=1100 rdata=ffff80ff", o_be, o_rdata); end
      drive32(1'b1, 1'b0, F3_HU, 32'h0000_0102, 32'h0, 32'h80FF_1234, 0, 1);
      total++; if (o_rdata !== 32'h0000_80FF) begin bad++; $display("FAIL lhu_rdata got=%h want=%h", o_rdata, 32'h0000_80FF); end
      drive32(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0, 32'h80FF_1234, 0, 1);
      total++; if (o_be !== 4'b1111 || o_rdata !== 32'h80FF_1234) begin bad++; $display("FAIL lw got be=%b rdata=%h want be=1111 rdata=80ff1234", o_be, o_rdata); end
   endtask

   task automatic test_store_delayed;
      drive32(1'b0, 1'b1, F3_H, 32'h0000_0202, 32'h0000_ABCD, 32'hDEAD_BEEF, 4, 1);
      total++; if (o_be !== 4'b1100) begin bad++; $display("FAIL sh_req_be got=%b want=%b", o_be, 4'b1100); end
      total++; if (o_wdata !== 32'hABCD_0000) begin bad++; $display("FAIL sh_req_wdata got=%h want=%h", o_wdata, 32'hABCD_0000); end
      total++; if (o_addr !== 32'h0000_0200 || o_we !== 1'b1) begin bad++; $display("FAIL sh_req_addr_we got addr=%h we=%b want 00000200 1", o_addr, o_we); end
      total++; if (o_stable !== 1'b1 || o_rv !== 5) begin bad++; $display("FAIL sh_req_stable got stable=%b req_cycles=%0d want 1 5", o_stable, o_rv); end
      total++; if (o_stall !== 7 || o_done !== 1'b1) begin bad++; $display("FAIL sh_stall_until_ack got stall=%0d done=%b want 7 1", o_stall, o_done); end
      total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL sh_rdata got=%h want=00000000", o_rdata); end
      drive32(1'b0, 1'b1, F3_B, 32'h0000_0201, 32'h1122_335A, 32'hDEAD_BEEF, 0, 1);
      total++; if (o_be !== 4'b0010 || o_wdata !== 32'h2233_5A00 || o_stall !== 3) begin bad++; $display("FAIL sb got be=%b wdata=%h stall=%0d want 0010 22335a00 3", o_be, o_wdata, o_stall); end
   endtask

   task automatic test_faults32;
      drive32(1'b1, 1'b0, F3_W, 32'h0000_0101, 32'h0, 32'h0, 0, 1);
      total++; if (o_fault !== 1 || o_rv !== 0 || o_stall !== 0) begin bad++; $display("FAIL lw_misaligned got fault=%0d req=%0d stall=%0d want 1 0 0", o_fault, o_rv, o_stall); end
      drive32(1'b1, 1'b1, F3_W, 32'h0000_0100, 32'h0, 32'h0, 0, 1);
      total++; if (o_fault !== 1 || o_rv !== 0 || o_stall !== 0) begin bad++; $display("FAIL read_and_write got fault=%0d req=%0d stall=%0d want 1 0 0", o_fault, o_rv, o_stall); end
      drive32(1'b1, 1'b0, F3_D, 32'h0000_0100, 32'h0, 32'h0, 0, 1);
      total++; if (o_fault !== 1 || o_rv !== 0 || o_stall !== 0) begin bad++; $display("FAIL ld_on_xlen32 got fault=%0d req=%0d stall=%0d want 1 0 0", o_fault, o_rv, o_stall); end
      drive32(1'b0, 1'b1, F3_BU, 32'h0000_0100, 32'h0, 32'h0, 0, 1);
      total++; if (o_fault !== 1 || o_rv !== 0) begin bad++; $display("FAIL unsigned_store got fault=%0d req=%0d want 1 0", o_fault, o_rv); end
      drive32(1'b1, 1'b0, F3_H, 32'h0000_0101, 32'h0, 32'h0, 0, 1);
      total++; if (o_fault !== 1 || o_rv !== 0) begin bad++; $display("FAIL lh_misaligned got fault=%0d req=%0d want 1 0", o_fault, o_rv); end
   endtask

   task automatic test_timeout;
      drive32(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, 0);
      total++; if (o_stall !== 6 || o_done !== 1'b1) begin bad++; $display("FAIL timeout_stall got stall=%0d done=%b want 6 1", o_stall, o_done); end
      total++; if (o_terr_done !== 1'b1 || o_terr !== 1) begin bad++; $display("FAIL timeout_err_pulse got in_done=%b cycles=%0d want 1 1", o_terr_done, o_terr); end
      total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL timeout_rdata got=%h want=00000000", o_rdata); end
      drive32(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, 4);
      total++; if (o_stall !== 6 || o_terr !== 0 || o_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rsp_on_last_wait got stall=%0d terr=%0d rdata=%h want 6 0 12345678", o_stall, o_terr, o_rdata); end
   endtask

   task automatic test_reset_mid_wait;
      int leak = 0;
      @(posedge clock); #1;
      a_rd = 1'b1; a_wr = 1'b0; a_f3 = F3_W; a_addr = 32'h0000_0100;
      a_ready = 1'b1; a_rsp_rdata = 32'hCAFE_F00D; a_rsp_valid = 1'b0;
      @(posedge clock);
      @(posedge clock);
      @(posedge clock); #1;
      total++; if (a_stall !== 1'b1 || a_req_valid !== 1'b0) begin bad++; $display("FAIL mid_wait_before_reset got stall=%b req_valid=%b want 1 0", a_stall, a_req_valid); end
      rst_n = 1'b0; a_rd = 1'b0; a_ready = 1'b0;
      #1;
      total++; if ({a_stall, a_fault, a_terr, a_req_valid, a_req_we, a_req_be} !== 9'h0 || a_rdata !== 32'h0 || a_req_addr !== 32'h0 || a_req_wdata !== 32'h0) begin bad++; $display("FAIL reset_mid_wait got stall=%b req_valid=%b addr=%h want all zero", a_stall, a_req_valid, a_req_addr); end
      @(posedge clock); #1; rst_n = 1'b1;
      @(posedge clock); #1; a_rsp_valid = 1'b1;
      @(posedge clock); #1; a_rsp_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (a_stall || a_req_valid || a_terr || a_rdata != 32'h0) leak++;
      end
      total++; if (leak !== 0) begin bad++; $display("FAIL stray_rsp_after_reset got active_cycles=%0d want=0", leak); end
   endtask

   task automatic test_xlen64;
      drive64(F3_WU, 32'h0000_1004, 64'h8765_4321_0000_0000);
      total++; if (q_be !== 8'hF0 || q_addr !== 32'h0000_1000) begin bad++; $display("FAIL lwu64_req got be=%h addr=%h want f0 00001000", q_be, q_addr); end
      total++; if (q_done !== 1'b1 || q_rdata !== 64'h0000_0000_8765_4321) begin bad++; $display("FAIL lwu64_rdata got=%h want=%h", q_rdata, 64'h0000_0000_8765_4321); end
      total++; if (q_stall !== 3) begin bad++; $display("FAIL lwu64_stall got=%0d want=3", q_stall); end
      drive64(F3_W, 32'h0000_1004, 64'h8765_4321_0000_0000);
      total++; if (q_rdata !== 64'hFFFF_FFFF_8765_4321) begin bad++; $display("FAIL lw64_rdata got=%h want=%h", q_rdata, 64'hFFFF_FFFF_8765_4321); end
      drive64(F3_D, 32'h0000_1000, 64'h8765_4321_0000_0000);
      total++; if (q_be !== 8'hFF || q_rdata !== 64'h8765_4321_0000_0000) begin bad++; $display("FAIL ld64 got be=%h rdata=%h want ff 8765432100000000", q_be, q_rdata); end
      drive64(F3_D, 32'h0000_1004, 64'h8765_4321_0000_0000);
      total++; if (q_fault !== 1 || q_rv !== 0 || q_stall !== 0) begin bad++; $display("FAIL ld64_misaligned got fault=%0d req=%0d stall=%0d want 1 0 0", q_fault, q_rv, q_stall); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      a_rd = 1'b0; a_wr = 1'b0; a_f3 = 3'b000; a_addr = 32'h0; a_wdata = 32'h0;
      a_ready = 1'b0; a_rsp_valid = 1'b0; a_rsp_rdata = 32'h0;
      b_rd = 1'b0; b_wr = 1'b0; b_f3 = 3'b000; b_addr = 32'h0; b_wdata = 64'h0;
      b_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_rdata = 64'h0;
      test_reset;
      test_loads32;
      test_store_delayed;
      test_faults32;
      test_timeout;
      test_reset_mid_wait;
      test_xlen64;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Parametrised load/store unit between the core datapath and the data cache. Successor to the single-cycle core's direct ReadData/WriteData/MemRead/MemWrite/stall coupling.
- Handles byte/half/word (and double, XLEN=64) accesses: lane alignment, byte enables, sign/zero extension, misalignment detection and a response timeout.
- Drives a valid/ready request channel and a valid-only response channel to the cache.
- Holds the core via stall until the access commits.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- TIMEOUT, 255, maximum WAIT cycles before abort; must be at least 1.
- NB, XLEN/8, byte lanes (derived, not overridable).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- mem_read  in  1  core load request.
- mem_write  in  1  core store request.
- funct3  in  3  access size/sign (RISC-V load/store encoding).
- addr  in  ADDR_W  byte address (ALUResult).
- wdata  in  XLEN  store data (rs2).
- rdata  out  XLEN  formatted load data; valid in DONE.
- stall  out  1  freezes PC and register write.
- fault  out  1  one-cycle pulse: misaligned, illegal size, or both read and write set.
- timeout_err  out  1  one-cycle pulse: cache response missing.
- req_valid  out  1  cache request valid.
- req_ready  in  1  cache accepts request.
- req_we  out  1  1 = store.
- req_addr  out  ADDR_W  NB-aligned address (low log2(NB) bits zero).
- req_wdata  out  XLEN  lane-shifted store data.
- req_be  out  NB  byte enables.
- rsp_valid  in  1  cache response or store acknowledge.
- rsp_rdata  in  XLEN  raw aligned line word.

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0; captured request cleared.
- Reset mid-access abandons the transaction. A late rsp_valid arriving in IDLE is ignored.
- Access = mem_read or mem_write.
- Sizes: funct3[1:0] gives 1/2/4/8 bytes. Size 8 is legal only when XLEN=64.
- Sign: funct3[2]=1 means zero-extend; it is illegal for stores and for 8-byte accesses.
- Misaligned: addr is not a multiple of the access size.
- States:
  - IDLE, access legal: capture we/addr/size/sign/wdata. stall=1 combinationally in the same cycle. Go to REQ.
  - IDLE, access illegal: fault=1 for that cycle, stall=0, no request; stay in IDLE.
  - REQ: req_valid=1 with registered fields. On req_ready, go to WAIT and clear the counter. rsp_valid in REQ is ignored; the cache responds at least one cycle after the handshake. req fields are stable while req_valid=1 and req_ready=0.
  - WAIT: counter increments each cycle. On rsp_valid, register the formatted data and go to DONE. If counter==TIMEOUT with no rsp_valid, go to DONE with rdata=0 and timeout_err=1 in DONE. rsp_valid in the same cycle as the timeout takes priority and there is no error.
  - DONE: stall=0 for exactly one cycle so the core commits. Then go to IDLE. DONE does not re-sample the still-present access.
- stall = (IDLE & legal access) | REQ | WAIT.
- Byte enables: be = ((1 << size) - 1) << addr[log2(NB)-1:0].
- Store data: req_wdata = wdata << (8 × lane offset).
- Load data: shift rsp_rdata right by 8 × lane offset, then sign- or zero-extend from the access size to XLEN. A load of the full XLEN passes through unchanged.
- Stores also wait for rsp_valid as an acknowledge; rdata is 0 for stores.
- Latency: a legal access with immediate req_ready and the response on the next cycle gives stall for 3 cycles (IDLE, REQ, WAIT), then DONE.

Decomposition:
- Package lsu_pkg holds:
  - state enum (IDLE, REQ, WAIT, DONE);
  - funct3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - function size_bytes(funct3).
- One combinational sub-module, lsu_align, computes be, req_wdata, the load extract/extend and the legality check. The FSM and counter stay in lsu_mem_port.

Test Plan:
- Reset low mid-WAIT, then a rsp_valid after release: outputs 0, state IDLE, stray response ignored, no DONE.
- LB at addr 0x103, rsp_rdata 0x80FF_1234, XLEN=32, req_ready=1 immediately, response 1 cycle later:
  - req_addr 0x100, req_be 0b1000;
  - rdata 0xFFFF_FF80;
  - stall high exactly 3 cycles.
- SH of wdata 0x0000_ABCD at 0x202 with req_ready delayed 4 cycles:
  - req_be 0b1100, req_wdata 0xABCD_0000;
  - req fields stable while waiting;
  - stall released only after the ack.
- LW at 0x101: fault pulse for 1 cycle, req_valid never asserted, stall 0.
- Same access with mem_read and mem_write both high: fault pulse for 1 cycle, req_valid never asserted, stall 0.
- TIMEOUT=4, no rsp_valid: DONE after 4 WAIT cycles with timeout_err=1 for 1 cycle and rdata=0. Repeat with rsp_valid on the 4th cycle: data returned, no error.
- XLEN=64, LWU at 0x1004, rsp_rdata 0x8765_4321_0000_0000: req_be 0xF0, rdata 0x0000_0000_8765_4321. Then LD at 0x1004: fault pulse.
